// File: rtl/l2_set_state_ctrl.sv
// l2_set_state_ctrl: per-set tag / MESI / LRU-rank state engine for the L2 controller.
// One request in flight at a time: IDLE -> LOOKUP -> UPDATE, or IDLE -> CLR sweep.
module l2_set_state_ctrl #(
    parameter  int ASSOC = 4,
    parameter  int SETS  = 16,
    parameter  int TAG_W = 12,
    localparam int LRU_W = $clog2(ASSOC),
    localparam int IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             req_shared,
    output logic             resp_valid,
    output logic             resp_hit,
    output logic [LRU_W-1:0] resp_way,
    output logic [1:0]       resp_mesi,
    output logic [2:0]       resp_bus_op,
    output logic [1:0]       resp_snoop,
    output logic             resp_evict,
    output logic [TAG_W-1:0] resp_evict_tag
);

    localparam logic [2:0] OP_CPU_RD  = 3'd0;
    localparam logic [2:0] OP_CPU_WR  = 3'd1;
    localparam logic [2:0] OP_SN_RD   = 3'd2;
    localparam logic [2:0] OP_SN_WR   = 3'd3;
    localparam logic [2:0] OP_SN_INV  = 3'd4;
    localparam logic [2:0] OP_SN_RWIM = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;

    localparam logic [1:0] MESI_INV  = 2'd0;
    localparam logic [1:0] MESI_MOD  = 2'd1;
    localparam logic [1:0] MESI_EXCL = 2'd2;
    localparam logic [1:0] MESI_SHRD = 2'd3;

    localparam logic [2:0] BUS_NONE  = 3'd0;
    localparam logic [2:0] BUS_READ  = 3'd1;
    localparam logic [2:0] BUS_INVAL = 3'd3;
    localparam logic [2:0] BUS_RWIM  = 3'd4;

    localparam logic [1:0] SNP_NOTHIT = 2'd0;
    localparam logic [1:0] SNP_HIT    = 2'd1;
    localparam logic [1:0] SNP_HITM   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_CLR} state_t;

    state_t state_q, state_d;

    logic [TAG_W-1:0] tag_arr  [SETS][ASSOC];
    logic [1:0]       mesi_arr [SETS][ASSOC];
    logic [LRU_W-1:0] rank_arr [SETS][ASSOC];

    logic [2:0]       cap_op;
    logic [IDX_W-1:0] cap_idx;
    logic [TAG_W-1:0] cap_tag;
    logic             cap_shared;
    logic [IDX_W-1:0] clr_idx;

    logic             lk_hit;
    logic [LRU_W-1:0] lk_hit_way, lk_victim;
    logic [TAG_W-1:0] lk_tag  [ASSOC];
    logic [1:0]       lk_mesi [ASSOC];
    logic [LRU_W-1:0] lk_rank [ASSOC];

    logic             hit_c;
    logic [LRU_W-1:0] hit_way_c, victim_c;

    logic [TAG_W-1:0] new_tag  [ASSOC];
    logic [1:0]       new_mesi [ASSOC];
    logic [LRU_W-1:0] new_rank [ASSOC];
    logic [LRU_W-1:0] acc_way;
    logic             touch, demote;
    logic             u_hit, u_evict;
    logic [LRU_W-1:0] u_way;
    logic [1:0]       u_mesi, u_snoop;
    logic [2:0]       u_bus;
    logic [TAG_W-1:0] u_evict_tag;

    assign req_ready = (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (req_valid) state_d = (req_op == OP_CLEAR) ? S_CLR : S_LOOKUP;
            S_LOOKUP: state_d = S_UPDATE;
            S_UPDATE: state_d = S_IDLE;
            S_CLR:    if (clr_idx == IDX_W'(SETS - 1)) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Victim preference: lowest-index invalid way beats the rank-0 (LRU) way.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        victim_c  = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (mesi_arr[cap_idx][w] != MESI_INV && tag_arr[cap_idx][w] == cap_tag) begin
                hit_c     = 1'b1;
                hit_way_c = LRU_W'(w);
            end
            if (rank_arr[cap_idx][w] == '0) victim_c = LRU_W'(w);
        end
        for (int w = ASSOC - 1; w >= 0; w--) begin
            if (mesi_arr[cap_idx][w] == MESI_INV) victim_c = LRU_W'(w);
        end
    end

    always_comb begin
        for (int w = 0; w < ASSOC; w++) begin
            new_tag[w]  = lk_tag[w];
            new_mesi[w] = lk_mesi[w];
            new_rank[w] = lk_rank[w];
        end
        acc_way     = lk_hit ? lk_hit_way : lk_victim;
        touch       = 1'b0;
        demote      = 1'b0;
        u_hit       = 1'b0;
        u_way       = '0;
        u_mesi      = MESI_INV;
        u_bus       = BUS_NONE;
        u_snoop     = SNP_NOTHIT;
        u_evict     = 1'b0;
        u_evict_tag = '0;
        case (cap_op)
            OP_CPU_RD, OP_CPU_WR: begin
                touch = 1'b1;
                u_hit = lk_hit;
                u_way = acc_way;
                if (lk_hit) begin
                    if (cap_op == OP_CPU_WR) begin
                        new_mesi[acc_way] = MESI_MOD;
                        u_bus = (lk_mesi[acc_way] == MESI_SHRD) ? BUS_INVAL : BUS_NONE;
                    end
                end else begin
                    u_evict           = (lk_mesi[acc_way] == MESI_MOD);
                    u_evict_tag       = u_evict ? lk_tag[acc_way] : '0;
                    new_tag[acc_way]  = cap_tag;
                    if (cap_op == OP_CPU_WR) begin
                        new_mesi[acc_way] = MESI_MOD;
                        u_bus             = BUS_RWIM;
                    end else begin
                        new_mesi[acc_way] = cap_shared ? MESI_SHRD : MESI_EXCL;
                        u_bus             = BUS_READ;
                    end
                end
                u_mesi = new_mesi[acc_way];
            end
            OP_SN_RD: if (lk_hit) begin
                u_hit             = 1'b1;
                u_way             = acc_way;
                u_snoop           = (lk_mesi[acc_way] == MESI_MOD) ? SNP_HITM : SNP_HIT;
                new_mesi[acc_way] = MESI_SHRD;
                u_mesi            = MESI_SHRD;
            end
            OP_SN_RWIM: if (lk_hit) begin
                u_hit             = 1'b1;
                u_way             = acc_way;
                u_snoop           = (lk_mesi[acc_way] == MESI_MOD) ? SNP_HITM : SNP_HIT;
                new_mesi[acc_way] = MESI_INV;
                demote            = 1'b1;
            end
            OP_SN_INV: if (lk_hit) begin
                u_hit = 1'b1;
                u_way = acc_way;
                if (lk_mesi[acc_way] == MESI_SHRD) begin
                    u_snoop           = SNP_HIT;
                    new_mesi[acc_way] = MESI_INV;
                    demote            = 1'b1;
                end
                u_mesi = new_mesi[acc_way];
            end
            OP_SN_WR: if (lk_hit) begin
                u_hit  = 1'b1;
                u_way  = acc_way;
                u_mesi = lk_mesi[acc_way];
            end
            default: ;
        endcase
        // Touch promotes to MRU, demote pushes to LRU; both keep ranks a permutation.
        if (touch || demote) begin
            for (int w = 0; w < ASSOC; w++) begin
                if (LRU_W'(w) == acc_way)
                    new_rank[w] = touch ? LRU_W'(ASSOC - 1) : '0;
                else if (touch && lk_rank[w] > lk_rank[acc_way])
                    new_rank[w] = lk_rank[w] - LRU_W'(1);
                else if (demote && lk_rank[w] < lk_rank[acc_way])
                    new_rank[w] = lk_rank[w] + LRU_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cap_op         <= '0;
            cap_idx        <= '0;
            cap_tag        <= '0;
            cap_shared     <= 1'b0;
            clr_idx        <= '0;
            lk_hit         <= 1'b0;
            lk_hit_way     <= '0;
            lk_victim      <= '0;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_mesi      <= '0;
            resp_bus_op    <= '0;
            resp_snoop     <= '0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
            for (int w = 0; w < ASSOC; w++) begin
                lk_tag[w]  <= '0;
                lk_mesi[w] <= MESI_INV;
                lk_rank[w] <= LRU_W'(w);
            end
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < ASSOC; w++) begin
                    tag_arr[s][w]  <= '0;
                    mesi_arr[s][w] <= MESI_INV;
                    rank_arr[s][w] <= LRU_W'(w);
                end
            end
        end else begin
            state_q        <= state_d;
            resp_valid     <= 1'b0;
            resp_hit       <= 1'b0;
            resp_way       <= '0;
            resp_mesi      <= '0;
            resp_bus_op    <= '0;
            resp_snoop     <= '0;
            resp_evict     <= 1'b0;
            resp_evict_tag <= '0;
            case (state_q)
                S_IDLE: if (req_valid) begin
                    cap_op     <= req_op;
                    cap_idx    <= req_idx;
                    cap_tag    <= req_tag;
                    cap_shared <= req_shared;
                    clr_idx    <= '0;
                end
                S_LOOKUP: begin
                    lk_hit     <= hit_c;
                    lk_hit_way <= hit_way_c;
                    lk_victim  <= victim_c;
                    for (int w = 0; w < ASSOC; w++) begin
                        lk_tag[w]  <= tag_arr[cap_idx][w];
                        lk_mesi[w] <= mesi_arr[cap_idx][w];
                        lk_rank[w] <= rank_arr[cap_idx][w];
                    end
                end
                S_UPDATE: begin
                    for (int w = 0; w < ASSOC; w++) begin
                        tag_arr[cap_idx][w]  <= new_tag[w];
                        mesi_arr[cap_idx][w] <= new_mesi[w];
                        rank_arr[cap_idx][w] <= new_rank[w];
                    end
                    resp_valid     <= 1'b1;
                    resp_hit       <= u_hit;
                    resp_way       <= u_way;
                    resp_mesi      <= u_mesi;
                    resp_bus_op    <= u_bus;
                    resp_snoop     <= u_snoop;
                    resp_evict     <= u_evict;
                    resp_evict_tag <= u_evict_tag;
                end
                S_CLR: begin
                    for (int w = 0; w < ASSOC; w++) begin
                        mesi_arr[clr_idx][w] <= MESI_INV;
                        rank_arr[clr_idx][w] <= LRU_W'(w);
                    end
                    clr_idx <= clr_idx + IDX_W'(1);
                    if (clr_idx == IDX_W'(SETS - 1)) resp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_set_state_ctrl.sv
// Self-checking bench for l2_set_state_ctrl: recency-list reference model plus
// per-cycle compare process and hand-computed literal checks.
module tb_l2_set_state_ctrl;

    localparam int ASSOC = 4;
    localparam int SETS  = 16;
    localparam int TAG_W = 12;
    localparam int LRU_W = 2;
    localparam int IDX_W = 4;

    localparam logic [2:0] OP_CPU_RD  = 3'd0;
    localparam logic [2:0] OP_CPU_WR  = 3'd1;
    localparam logic [2:0] OP_SN_RD   = 3'd2;
    localparam logic [2:0] OP_SN_WR   = 3'd3;
    localparam logic [2:0] OP_SN_INV  = 3'd4;
    localparam logic [2:0] OP_SN_RWIM = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_NOP     = 3'd7;

    localparam int INV = 0, MOD = 1, EXCL = 2, SHRD = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_shared;
    logic             resp_valid;
    logic             resp_hit;
    logic [LRU_W-1:0] resp_way;
    logic [1:0]       resp_mesi;
    logic [2:0]       resp_bus_op;
    logic [1:0]       resp_snoop;
    logic             resp_evict;
    logic [TAG_W-1:0] resp_evict_tag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int due   = 0;
    bit have_req = 1'b0;

    int m_tag [SETS][ASSOC];
    int m_st  [SETS][ASSOC];
    int m_ord [SETS][ASSOC];
    int e_hit, e_way, e_mesi, e_bus, e_snoop, e_evict, e_etag;

    l2_set_state_ctrl #(.ASSOC(ASSOC), .SETS(SETS), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_idx        (req_idx),
        .req_tag        (req_tag),
        .req_shared     (req_shared),
        .resp_valid     (resp_valid),
        .resp_hit       (resp_hit),
        .resp_way       (resp_way),
        .resp_mesi      (resp_mesi),
        .resp_bus_op    (resp_bus_op),
        .resp_snoop     (resp_snoop),
        .resp_evict     (resp_evict),
        .resp_evict_tag (resp_evict_tag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    // Each set keeps an ordered list of ways, LRU first, MRU last.
    task automatic modelReset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < ASSOC; w++) begin
                m_tag[s][w] = 0;
                m_st[s][w]  = INV;
                m_ord[s][w] = w;
            end
        have_req = 1'b0;
        due      = cyc;
    endtask

    task automatic makeMru(input int s, input int w);
        int pos = 0;
        for (int i = 0; i < ASSOC; i++) if (m_ord[s][i] == w) pos = i;
        for (int i = pos; i < ASSOC - 1; i++) m_ord[s][i] = m_ord[s][i+1];
        m_ord[s][ASSOC-1] = w;
    endtask

    task automatic makeLru(input int s, input int w);
        int pos = 0;
        for (int i = 0; i < ASSOC; i++) if (m_ord[s][i] == w) pos = i;
        for (int i = pos; i > 0; i--) m_ord[s][i] = m_ord[s][i-1];
        m_ord[s][0] = w;
    endtask

    function automatic int pickVictim(input int s);
        for (int w = 0; w < ASSOC; w++) if (m_st[s][w] == INV) return w;
        return m_ord[s][0];
    endfunction

    task automatic modelAccess(input int op, input int s, input int tg, input bit sh);
        int hw = -1;
        int w;
        e_hit = 0; e_way = 0; e_mesi = 0; e_bus = 0; e_snoop = 0; e_evict = 0; e_etag = 0;
        for (int i = 0; i < ASSOC; i++)
            if (m_st[s][i] != INV && m_tag[s][i] == tg) hw = i;
        case (op)
            0, 1: begin
                if (hw >= 0) begin
                    w = hw;
                    e_hit = 1;
                    if (op == 1) begin
                        if (m_st[s][w] == SHRD) e_bus = 3;
                        m_st[s][w] = MOD;
                    end
                end else begin
                    w = pickVictim(s);
                    if (m_st[s][w] == MOD) begin
                        e_evict = 1;
                        e_etag  = m_tag[s][w];
                    end
                    m_tag[s][w] = tg;
                    m_st[s][w]  = (op == 1) ? MOD : (sh ? SHRD : EXCL);
                    e_bus       = (op == 1) ? 4 : 1;
                end
                makeMru(s, w);
                e_way  = w;
                e_mesi = m_st[s][w];
            end
            2: if (hw >= 0) begin
                e_hit = 1; e_way = hw;
                e_snoop = (m_st[s][hw] == MOD) ? 2 : 1;
                m_st[s][hw] = SHRD;
                e_mesi = SHRD;
            end
            5: if (hw >= 0) begin
                e_hit = 1; e_way = hw;
                e_snoop = (m_st[s][hw] == MOD) ? 2 : 1;
                m_st[s][hw] = INV;
                makeLru(s, hw);
            end
            4: if (hw >= 0) begin
                e_hit = 1; e_way = hw;
                if (m_st[s][hw] == SHRD) begin
                    e_snoop = 1;
                    m_st[s][hw] = INV;
                    makeLru(s, hw);
                end
                e_mesi = m_st[s][hw];
            end
            3: if (hw >= 0) begin
                e_hit = 1; e_way = hw; e_mesi = m_st[s][hw];
            end
            6: begin
                for (int ss = 0; ss < SETS; ss++)
                    for (int ww = 0; ww < ASSOC; ww++) begin
                        m_st[ss][ww]  = INV;
                        m_ord[ss][ww] = ww;
                    end
            end
            default: ;
        endcase
    endtask

    // Per-cycle comparison against the model's handshake timing and response.
    always @(negedge clk) begin
        logic exp_ready, exp_valid;
        exp_ready = (cyc >= due);
        exp_valid = have_req && (cyc == due);
        total++;
        if (req_ready !== exp_ready) begin
            bad++;
            $display("[TB] FAIL ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_ready);
        end
        total++;
        if (resp_valid !== exp_valid) begin
            bad++;
            $display("[TB] FAIL resp_valid cyc=%0d got=%b want=%b", cyc, resp_valid, exp_valid);
        end
        if (exp_valid) begin
            total++;
            if (resp_hit !== 1'(e_hit) || resp_way !== LRU_W'(e_way) || resp_mesi !== 2'(e_mesi) ||
                resp_bus_op !== 3'(e_bus) || resp_snoop !== 2'(e_snoop) ||
                resp_evict !== 1'(e_evict) || resp_evict_tag !== TAG_W'(e_etag)) begin
                bad++;
                $display("[TB] FAIL model_resp cyc=%0d got h%b w%0d m%0d b%0d s%0d e%b t%h want h%0d w%0d m%0d b%0d s%0d e%0d t%h",
                         cyc, resp_hit, resp_way, resp_mesi, resp_bus_op, resp_snoop, resp_evict,
                         resp_evict_tag, e_hit, e_way, e_mesi, e_bus, e_snoop, e_evict, e_etag);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [IDX_W-1:0] idx,
                                 input logic [TAG_W-1:0] tg, input logic sh);
        while (cyc < due) begin
            @(posedge clk);
            #1;
        end
        req_valid  = 1'b1;
        req_op     = op;
        req_idx    = idx;
        req_tag    = tg;
        req_shared = sh;
        @(posedge clk);
        #1;
        modelAccess(int'(op), int'(idx), int'(tg), sh);
        have_req   = 1'b1;
        due        = cyc + ((op == OP_CLEAR) ? SETS : 2);
        req_valid  = 1'b0;
        req_op     = 3'($urandom_range(0, 7));
        req_idx    = IDX_W'($urandom);
        req_tag    = TAG_W'($urandom);
        req_shared = 1'($urandom);
    endtask

    task automatic waitResp();
        while (cyc < due) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic v, input logic rdy, input logic h,
                               input int way, input int mesi, input int bus, input int snp,
                               input logic ev, input int etag);
        total++;
        if (resp_valid !== v || req_ready !== rdy || resp_hit !== h || resp_way !== LRU_W'(way) ||
            resp_mesi !== 2'(mesi) || resp_bus_op !== 3'(bus) || resp_snoop !== 2'(snp) ||
            resp_evict !== ev || resp_evict_tag !== TAG_W'(etag)) begin
            bad++;
            $display("[TB] FAIL %s got v%b r%b h%b w%0d m%0d b%0d s%0d e%b t%h want v%b r%b h%b w%0d m%0d b%0d s%0d e%b t%h",
                     name, resp_valid, req_ready, resp_hit, resp_way, resp_mesi, resp_bus_op,
                     resp_snoop, resp_evict, resp_evict_tag, v, rdy, h, way, mesi, bus, snp, ev, etag);
        end
    endtask

    initial begin
        int low_cnt;
        req_valid = 1'b0; req_op = '0; req_idx = '0; req_tag = '0; req_shared = 1'b0;
        rst = 1'b1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset", 0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Basic fill, write upgrade, snoop of a modified line, and a NOP.
        applyStimulus(OP_CPU_RD, 4'd3, 12'h0AB, 1'b0); waitResp();
        checkOutput("rd_miss", 1, 1, 0, 0, EXCL, 1, 0, 0, 0);
        applyStimulus(OP_CPU_WR, 4'd3, 12'h0AB, 1'b0); waitResp();
        checkOutput("wr_hit_excl", 1, 1, 1, 0, MOD, 0, 0, 0, 0);
        applyStimulus(OP_SN_RD, 4'd3, 12'h0AB, 1'b0); waitResp();
        checkOutput("snrd_hitm", 1, 1, 1, 0, SHRD, 0, 2, 0, 0);
        applyStimulus(OP_NOP, 4'd3, 12'h0AB, 1'b1); waitResp();
        checkOutput("nop", 1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Full set of modified lines, touch way 0, then a miss must evict way 1.
        for (int i = 0; i < 4; i++) applyStimulus(OP_CPU_WR, 4'd5, 12'h100 + 12'(i), 1'b0);
        applyStimulus(OP_CPU_RD, 4'd5, 12'h100, 1'b0); waitResp();
        checkOutput("touch_w0", 1, 1, 1, 0, MOD, 0, 0, 0, 0);
        applyStimulus(OP_CPU_RD, 4'd5, 12'h104, 1'b0); waitResp();
        checkOutput("evict_w1", 1, 1, 0, 1, EXCL, 1, 0, 1, 12'h101);

        // Shared-line upgrade, RWIM snoop, reuse and LRU victim selection.
        applyStimulus(OP_CPU_RD, 4'd9, 12'h200, 1'b1); waitResp();
        checkOutput("rd_shared", 1, 1, 0, 0, SHRD, 1, 0, 0, 0);
        for (int i = 1; i < 4; i++) applyStimulus(OP_CPU_RD, 4'd9, 12'h200 + 12'(i), 1'b0);
        applyStimulus(OP_CPU_WR, 4'd9, 12'h200, 1'b0); waitResp();
        checkOutput("wr_shrd_inval", 1, 1, 1, 0, MOD, 3, 0, 0, 0);
        applyStimulus(OP_SN_RWIM, 4'd9, 12'h200, 1'b0); waitResp();
        checkOutput("rwim_hitm", 1, 1, 1, 0, INV, 0, 2, 0, 0);
        applyStimulus(OP_CPU_RD, 4'd9, 12'h204, 1'b0); waitResp();
        checkOutput("refill_w0", 1, 1, 0, 0, EXCL, 1, 0, 0, 0);
        applyStimulus(OP_CPU_RD, 4'd9, 12'h205, 1'b0); waitResp();
        checkOutput("lru_w1", 1, 1, 0, 1, EXCL, 1, 0, 0, 0);
        applyStimulus(OP_SN_RD, 4'd9, 12'h204, 1'b0);
        applyStimulus(OP_SN_INV, 4'd9, 12'h204, 1'b0); waitResp();
        checkOutput("sninv_shrd", 1, 1, 1, 0, INV, 0, 1, 0, 0);
        applyStimulus(OP_SN_INV, 4'd9, 12'h202, 1'b0);
        applyStimulus(OP_SN_WR, 4'd9, 12'h203, 1'b0);
        applyStimulus(OP_SN_RD, 4'd9, 12'h2FF, 1'b0); waitResp();
        checkOutput("snrd_miss", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(OP_CPU_RD, 4'd9, 12'h206, 1'b0);
        applyStimulus(OP_CPU_WR, 4'd9, 12'h207, 1'b0);

        // CLEAR sweep: busy for SETS cycles, then everything misses.
        applyStimulus(OP_CLEAR, 4'd0, 12'h000, 1'b0);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) break;
            if (!req_ready) low_cnt++;
            @(posedge clk);
            #1;
        end
        total++;
        if (low_cnt != SETS) begin
            bad++;
            $display("[TB] FAIL clr_busy got=%0d want=%0d", low_cnt, SETS);
        end
        checkOutput("clr_done", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(OP_CPU_RD, 4'd3, 12'h0AB, 1'b0); waitResp();
        checkOutput("after_clr_rd", 1, 1, 0, 0, EXCL, 1, 0, 0, 0);
        applyStimulus(OP_CPU_RD, 4'd5, 12'h100, 1'b0); waitResp();
        checkOutput("after_clr_mod", 1, 1, 0, 0, EXCL, 1, 0, 0, 0);

        // Reset in the middle of a CLEAR sweep (set 7).
        applyStimulus(OP_CPU_RD, 4'd12, 12'h3CC, 1'b0);
        applyStimulus(OP_CLEAR, 4'd0, 12'h000, 1'b0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_clr", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(OP_CPU_RD, 4'd12, 12'h3CC, 1'b0); waitResp();
        checkOutput("after_rst_clr", 1, 1, 0, 0, EXCL, 1, 0, 0, 0);

        // Reset while a write is in UPDATE: the write must not land.
        applyStimulus(OP_CPU_RD, 4'd2, 12'h055, 1'b0); waitResp();
        applyStimulus(OP_CPU_WR, 4'd2, 12'h055, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_upd", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(OP_CPU_RD, 4'd2, 12'h055, 1'b0); waitResp();
        checkOutput("after_rst_upd", 1, 1, 0, 0, EXCL, 1, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
